// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with predication, Z flag and memory timeout.
// Optional RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module multicycle_control_unit #(
  parameter int OP_W       = 5,
  parameter int COND_W     = 2,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Op,
  input  logic [COND_W-1:0] cond,
  input  logic              sf,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic              imem_req,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic [1:0]        PCSource,
  output logic [OP_W-1:0]   ALUOp,
  output logic              ALUSrc,
  output logic              SeSel,
  output logic              reg2sel,
  output logic [1:0]        RegDst,
  output logic [1:0]        Mem2Reg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              zero_flag,
  output logic [2:0]        state,
  output logic              bus_err
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [OP_W-1:0] OP_LWS  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(15);

  localparam int              CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W:0]  LIMIT = (CNT_W + 1)'(WAIT_LIMIT);

  logic [2:0]       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_dec;
  logic             z_q, berr_q, pred, timeout, waiting;
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W:0]   wait_inc;

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return (op == OP_W'(0)) || (op == OP_W'(1)) || (op == OP_W'(3)) || (op == OP_W'(4));
  endfunction

  // Squashed or unknown opcodes collapse to NOP before being latched
  always_comb begin
    pred = (cond == COND_W'(0)) || ((cond == COND_W'(1)) && z_q) || ((cond == COND_W'(2)) && !z_q);
    op_dec = (pred && (Op < OP_NOP)) ? Op : OP_NOP;
    waiting = (state_q == FETCH) || (state_q == MEM);
    wait_inc = {1'b0, wcnt_q} + {{CNT_W{1'b0}}, 1'b1};
    timeout = (WAIT_LIMIT > 0) && waiting && !mem_ready && (wait_inc == LIMIT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : (timeout ? HALT : FETCH);
      DECODE: begin
        if (!pred || op_dec == OP_J || op_dec == OP_JR || op_dec == OP_JAL || op_dec == OP_LUI)
          state_d = FETCH;
        else
          state_d = EXEC;
      end
      EXEC: begin
        if (op_q == OP_LW || op_q == OP_LWS || op_q == OP_SW)
          state_d = MEM;
        else if (is_rtype(op_q) || op_q == OP_ANDI || op_q == OP_ADDI)
          state_d = WB;
        else
          state_d = FETCH;
      end
      MEM: begin
        if (mem_ready)
          state_d = (op_q == OP_SW) ? FETCH : WB;
        else if (timeout)
          state_d = HALT;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSource = 2'd0;
    ALUOp    = '0;
    ALUSrc   = 1'b0;
    SeSel    = 1'b0;
    reg2sel  = 1'b0;
    RegDst   = 2'd0;
    Mem2Reg  = 2'd0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          IRWrite  = mem_ready;
          PCWrite  = mem_ready;
        end
        DECODE: begin
          case (op_dec)
            OP_J:   begin PCWrite = 1'b1; PCSource = 2'd1; end
            OP_JR:  begin PCWrite = 1'b1; PCSource = 2'd2; end
            OP_JAL: begin
              PCWrite = 1'b1; PCSource = 2'd1;
              RegWrite = 1'b1; RegDst = 2'd3; Mem2Reg = 2'd2;
            end
            OP_LUI: begin RegWrite = 1'b1; RegDst = 2'd2; Mem2Reg = 2'd3; end
            default: ;
          endcase
        end
        EXEC: begin
          ALUOp   = op_q;
          ALUSrc  = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ANDI) || (op_q == OP_ADDI);
          SeSel   = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_BEQ) ||
                    (op_q == OP_ANDI) || (op_q == OP_ADDI);
          reg2sel = (op_q == OP_SW) || (op_q == OP_BEQ);
          if (op_q == OP_BEQ && alu_zero) begin
            PCWrite  = 1'b1;
            PCSource = 2'd1;
          end
        end
        MEM: begin
          MemRead  = (op_q == OP_LW) || (op_q == OP_LWS);
          MemWrite = (op_q == OP_SW);
        end
        WB: begin
          RegWrite = 1'b1;
          RegDst   = (op_q == OP_LW) ? 2'd1 : 2'd0;
          Mem2Reg  = (op_q == OP_LW || op_q == OP_LWS) ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign zero_flag = !reset && z_q;
  assign bus_err   = !reset && berr_q;
  assign state     = reset ? FETCH : state_q;

  // Control state: wait counter restarts on every state entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      z_q     <= 1'b0;
      berr_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wcnt_q <= '0;
      else if (waiting)
        wcnt_q <= wait_inc[CNT_W-1:0];
      if (state_q == EXEC && (op_q == OP_CMP || sf))
        z_q <= alu_zero;
      if (timeout)
        berr_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == DECODE)
      op_q <= op_dec;
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (reset)
      retire_q <= '0;
    else if (state_d == FETCH && (state_q == DECODE || state_q == EXEC ||
                                  state_q == MEM || state_q == WB))
      retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = reset ? 32'd0 : retire_q;
`endif

endmodule
